// File: rtl/scrypt_pkg.sv
// Shared types and constants for the scrypt smix datapath.
package scrypt_pkg;

  localparam int unsigned SCRYPT_BLOCK_W = 1024;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_HOLD} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request above i_ptr, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    // Candidates in priority order: i_ptr+1, i_ptr+2, ..., i_ptr (last).
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % N);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_grant_idx      = w_cand;
      end
    end
  end

endmodule

// File: rtl/scrypt_smix_scheduler.sv
// Shares one smix engine between NUM_REQ requesters; round-robin grant, one job in flight.
module scrypt_smix_scheduler
  import scrypt_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BLK_W       = SCRYPT_BLOCK_W,
  parameter int unsigned TIMEOUT_CYC = 2200000,
  parameter int unsigned JOBS_W      = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*BLK_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [BLK_W-1:0]         o_smix_data,
  output logic                     o_smix_enable,
  input  logic [BLK_W-1:0]         i_smix_hash,
  input  logic                     i_smix_done,
  output logic                     o_res_valid,
  output logic [BLK_W-1:0]         o_res_data,
  output logic [IDX_W-1:0]         o_res_id,
  input  logic                     i_res_ready,
  output logic                     o_busy,
  output logic [JOBS_W-1:0]        o_jobs_done,
  output logic                     o_err_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  sched_state_t       r_state, w_state_d;
  logic [BLK_W-1:0]   r_job, w_job_d;
  logic [IDX_W-1:0]   r_id, w_id_d;
  logic [IDX_W-1:0]   r_ptr, w_ptr_d;
  logic [WD_W-1:0]    r_wd, w_wd_d;
  logic               r_err, w_err_d;
  logic [BLK_W-1:0]   r_res_data, w_res_data_d;
  logic [IDX_W-1:0]   r_res_id, w_res_id_d;
  logic [JOBS_W-1:0]  r_jobs, w_jobs_d;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [BLK_W-1:0]   w_req_blk;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .i_en        (r_state == S_IDLE),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  always_comb begin
    w_req_blk = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) w_req_blk = i_req_data[k*BLK_W +: BLK_W];
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_job_d      = r_job;
    w_id_d       = r_id;
    w_ptr_d      = r_ptr;
    w_wd_d       = r_wd;
    w_err_d      = r_err;
    w_res_data_d = r_res_data;
    w_res_id_d   = r_res_id;
    w_jobs_d     = r_jobs;
    case (r_state)
      S_IDLE: begin
        if (|(i_req_valid & w_grant)) begin
          w_job_d   = w_req_blk;
          w_id_d    = w_grant_idx;
          w_ptr_d   = w_grant_idx;
          w_state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_wd_d    = '0;
        w_state_d = S_RUN;
      end
      S_RUN: begin
        if (r_wd != WD_MAX) w_wd_d = r_wd + WD_W'(1);
        // No abort on timeout: flag it and keep waiting for the engine.
        if (w_wd_d == WD_MAX) w_err_d = 1'b1;
        if (i_smix_done) begin
          w_res_data_d = i_smix_hash;
          w_res_id_d   = r_id;
          w_state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_res_ready) begin
          w_jobs_d  = r_jobs + JOBS_W'(1);
          w_state_d = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_job      <= '0;
      r_id       <= '0;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_wd       <= '0;
      r_err      <= 1'b0;
      r_res_data <= '0;
      r_res_id   <= '0;
      r_jobs     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_job      <= w_job_d;
      r_id       <= w_id_d;
      r_ptr      <= w_ptr_d;
      r_wd       <= w_wd_d;
      r_err      <= w_err_d;
      r_res_data <= w_res_data_d;
      r_res_id   <= w_res_id_d;
      r_jobs     <= w_jobs_d;
    end
  end

  assign o_req_ready   = w_grant;
  assign o_smix_enable = (r_state == S_LAUNCH);
  assign o_smix_data   = r_job;
  assign o_res_valid   = (r_state == S_HOLD);
  assign o_res_data    = r_res_data;
  assign o_res_id      = r_res_id;
  assign o_busy        = (r_state != S_IDLE);
  assign o_jobs_done   = r_jobs;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_scrypt_smix_scheduler.sv
// Directed bench for scrypt_smix_scheduler with a behavioural smix engine (hash = ~data).
module tb_scrypt_smix_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned BW = 1024;
  localparam int unsigned TO = 100;
  localparam int unsigned JW = 8;
  localparam int unsigned IW = 2;

  logic             clk = 1'b0;
  logic             n_rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [BW-1:0]    smix_data;
  logic             smix_enable;
  logic [BW-1:0]    smix_hash;
  logic             smix_done;
  logic             res_valid;
  logic [BW-1:0]    res_data;
  logic [IW-1:0]    res_id;
  logic             res_ready = 1'b0;
  logic             busy;
  logic [JW-1:0]    jobs_done;
  logic             err_timeout;

  int total = 0;
  int bad = 0;

  // Engine model controls: done after eng_k cycles (0 = never), or at eng_late if nonzero.
  int            eng_k = 10;
  int            eng_late = 0;
  int            eng_cnt = 0;
  logic          eng_busy = 1'b0;
  logic [BW-1:0] eng_data = '0;

  always #5 clk = ~clk;

  scrypt_smix_scheduler #(
    .NUM_REQ     (NR),
    .BLK_W       (BW),
    .TIMEOUT_CYC (TO),
    .JOBS_W      (JW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .o_smix_data   (smix_data),
    .o_smix_enable (smix_enable),
    .i_smix_hash   (smix_hash),
    .i_smix_done   (smix_done),
    .o_res_valid   (res_valid),
    .o_res_data    (res_data),
    .o_res_id      (res_id),
    .i_res_ready   (res_ready),
    .o_busy        (busy),
    .o_jobs_done   (jobs_done),
    .o_err_timeout (err_timeout)
  );

  function automatic logic [BW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i) * 32'h0101_0011;
    return {32{w}};
  endfunction

  initial begin
    smix_done = 1'b0;
    smix_hash = '0;
    forever begin
      @(negedge clk);
      smix_done = 1'b0;
      if (!n_rst) begin
        eng_busy = 1'b0;
      end else if (eng_busy) begin
        eng_cnt++;
        if ((eng_k != 0 && eng_cnt == eng_k) || (eng_late != 0 && eng_cnt == eng_late)) begin
          smix_done = 1'b1;
          smix_hash = ~eng_data;
          eng_busy  = 1'b0;
        end
      end else if (smix_enable) begin
        eng_busy = 1'b1;
        eng_cnt  = 0;
        eng_data = smix_data;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_res(input int bound, output int n);
    n = 0;
    while (n <= bound) begin
      tick();
      n++;
      if (res_valid) break;
    end
  endtask

  task automatic test_reset;
    logic [BW-1:0] z;
    z = '0;
    #2 n_rst = 1'b0;
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    total++; if (smix_enable !== 1'b0) begin bad++; $display("FAIL rst_enable: got %b want 0", smix_enable); end
    total++; if (smix_data !== z) begin bad++; $display("FAIL rst_smix_data: nonzero"); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    total++; if (res_data !== z) begin bad++; $display("FAIL rst_res_data: nonzero"); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rst_res_id: got %0d want 0", res_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (jobs_done !== 8'd0) begin bad++; $display("FAIL rst_jobs: got %0d want 0", jobs_done); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    n_rst = 1'b1;
  endtask

  task automatic do_reset;
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_single;
    int n;
    logic [BW-1:0] e;
    eng_k = 10;
    tick();
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    e = pat(0);
    total++; if (smix_enable !== 1'b1) begin bad++; $display("FAIL single_enable: got %b want 1", smix_enable); end
    total++; if (smix_data !== e) begin bad++; $display("FAIL single_smix_data: got %h want %h", smix_data[63:0], e[63:0]); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_res(40, n);
    total++; if (n !== 11) begin bad++; $display("FAIL single_latency: got %0d want 11", n); end
    e = ~pat(0);
    total++; if (res_data !== e) begin bad++; $display("FAIL single_res_data: got %h want %h", res_data[63:0], e[63:0]); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL single_res_id: got %0d want 0", res_id); end
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_accept: got %b want 0", res_valid); end
    total++; if (jobs_done !== 8'd1) begin bad++; $display("FAIL single_jobs: got %0d want 1", jobs_done); end
    tick();
    total++; if (jobs_done !== 8'd1) begin bad++; $display("FAIL single_idle_ready: got %0d want 1", jobs_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    res_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    int g = 0;
    int r = 0;
    int last_g = 0;
    logic [NR-1:0] one;
    logic [BW-1:0] e;
    do_reset();
    eng_k = 1;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 80 && r < 5; c++) begin
      if (|req_ready) begin
        one = 4'b0001;
        one = one << order[g];
        total++; if (req_ready !== one) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, one); end
        if (g > 0) begin
          total++; if (c - last_g !== 4) begin bad++; $display("FAIL rr_gap%0d: got %0d want 4", g, c - last_g); end
        end
        last_g = c;
        g++;
      end
      if (res_valid) begin
        e = ~pat(order[r]);
        total++; if (res_id !== 2'(order[r])) begin bad++; $display("FAIL rr_res_id%0d: got %0d want %0d", r, res_id, order[r]); end
        total++; if (res_data !== e) begin bad++; $display("FAIL rr_res_data%0d: got %h want %h", r, res_data[63:0], e[63:0]); end
        r++;
      end
      tick();
      if (g >= 5) req_valid = '0;
      #1;
    end
    total++; if (r !== 5) begin bad++; $display("FAIL rr_results: got %0d want 5", r); end
    total++; if (jobs_done !== 8'd5) begin bad++; $display("FAIL rr_jobs: got %0d want 5", jobs_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy: got %b want 0", busy); end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    int bad_ready = 0;
    int bad_res = 0;
    logic [BW-1:0] e;
    eng_k = 3;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_res(20, n);
    total++; if (n !== 4) begin bad++; $display("FAIL bp_latency: got %0d want 4", n); end
    e = ~pat(1);
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 50; c++) begin
      if (req_ready !== 4'b0000) bad_ready++;
      if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== e || jobs_done !== 8'd5) bad_res++;
      tick();
    end
    total++; if (bad_ready !== 0) begin bad++; $display("FAIL bp_ready_held: got %0d bad cycles want 0", bad_ready); end
    total++; if (bad_res !== 0) begin bad++; $display("FAIL bp_res_stable: got %0d bad cycles want 0", bad_res); end
    res_ready = 1'b1;
    #1;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_accept_valid: got %b want 1", res_valid); end
    tick();
    res_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
    total++; if (jobs_done !== 8'd6) begin bad++; $display("FAIL bp_jobs: got %0d want 6", jobs_done); end
    tick();
    req_valid = '0;
    e = pat(2);
    total++; if (smix_enable !== 1'b1 || smix_data !== e) begin bad++; $display("FAIL bp_launch2: got en=%b data=%h want en=1 data=%h", smix_enable, smix_data[63:0], e[63:0]); end
    wait_res(20, n);
    total++; if (res_id !== 2'd2 || n !== 4) begin bad++; $display("FAIL bp_res2: got id=%0d n=%0d want id=2 n=4", res_id, n); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_watchdog;
    int bad_err = 0;
    int bad_rv = 0;
    logic [BW-1:0] e;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_pre: got %b want 0", err_timeout); end
    eng_k = 0;
    eng_late = 150;
    tick();
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wd_grant: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    total++; if (smix_enable !== 1'b1) begin bad++; $display("FAIL wd_enable: got %b want 1", smix_enable); end
    for (int n = 1; n <= 151; n++) begin
      tick();
      if (n == 100) begin
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0 after 99 run cycles", err_timeout); end
      end
      if (n == 101) begin
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wd_rise: got %b want 1 after 100 run cycles", err_timeout); end
      end
      if (n > 101 && err_timeout !== 1'b1) bad_err++;
      if (n < 151 && res_valid !== 1'b0) bad_rv++;
    end
    total++; if (bad_err !== 0) begin bad++; $display("FAIL wd_sticky: got %0d low cycles want 0", bad_err); end
    total++; if (bad_rv !== 0) begin bad++; $display("FAIL wd_no_early_res: got %0d cycles want 0", bad_rv); end
    e = ~pat(3);
    total++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== e) begin bad++; $display("FAIL wd_late_res: got v=%b id=%0d data=%h want v=1 id=3 data=%h", res_valid, res_id, res_data[63:0], e[63:0]); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    eng_late = 0;
    total++; if (err_timeout !== 1'b1 || jobs_done !== 8'd8) begin bad++; $display("FAIL wd_after: got err=%b jobs=%0d want err=1 jobs=8", err_timeout, jobs_done); end
  endtask

  task automatic test_reset_mid_run;
    int n;
    logic [BW-1:0] e;
    logic [BW-1:0] z;
    z = '0;
    eng_k = 20;
    tick();
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mr_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mr_busy_run: got %b want 1", busy); end
    n_rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || smix_enable !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL mr_ctrl: got busy=%b en=%b rv=%b want 0 0 0", busy, smix_enable, res_valid); end
    total++; if (smix_data !== z || res_data !== z || res_id !== 2'd0) begin bad++; $display("FAIL mr_data: got nonzero data/id want 0"); end
    total++; if (jobs_done !== 8'd0 || err_timeout !== 1'b0) begin bad++; $display("FAIL mr_status: got jobs=%0d err=%b want 0 0", jobs_done, err_timeout); end
    tick();
    n_rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mr_first_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    e = pat(0);
    total++; if (smix_enable !== 1'b1 || smix_data !== e) begin bad++; $display("FAIL mr_launch: got en=%b data=%h want en=1 data=%h", smix_enable, smix_data[63:0], e[63:0]); end
    wait_res(40, n);
    total++; if (n !== 21 || res_id !== 2'd0) begin bad++; $display("FAIL mr_res: got n=%0d id=%0d want n=21 id=0", n, res_id); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (jobs_done !== 8'd1) begin bad++; $display("FAIL mr_jobs: got %0d want 1", jobs_done); end
  endtask

  task automatic test_wrap;
    int acc = 0;
    int g = 0;
    int en = 0;
    int spur = 0;
    int mism = 0;
    logic prev = 1'b0;
    do_reset();
    eng_k = 1;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 1400 && acc < 256; c++) begin
      if (smix_enable && !prev) spur++;
      if (smix_enable) en++;
      if (jobs_done !== JW'(acc)) mism++;
      prev = |req_ready;
      if (|req_ready) g++;
      if (res_valid) acc++;
      tick();
      if (g >= 256) req_valid = '0;
      #1;
    end
    total++; if (acc !== 256) begin bad++; $display("FAIL wrap_results: got %0d want 256", acc); end
    total++; if (mism !== 0) begin bad++; $display("FAIL wrap_count_track: got %0d mismatched cycles want 0", mism); end
    total++; if (spur !== 0 || en !== 256) begin bad++; $display("FAIL wrap_enables: got spur=%0d en=%0d want 0 256", spur, en); end
    total++; if (jobs_done !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", jobs_done); end
    res_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = pat(i);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid_run();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500us");
    $fatal(1, "timeout");
  end

endmodule
